// File: rtl/divider_arbiter.sv
// Round-robin arbiter in front of a single shared iterative restoring divider.
// One result port carries quotient, remainder, divide-by-zero flag and requester ID.
module divider_arbiter #(
    parameter int g_Width    = 12,
    parameter int g_Id_Width = 2
) (
    input  logic                                   i_Clk,
    input  logic                                   i_Reset,
    input  logic [(2**g_Id_Width)-1:0]             i_Req_Valid,
    input  logic [(2**g_Id_Width)*g_Width-1:0]     i_Dividend,
    input  logic [(2**g_Id_Width)*g_Width-1:0]     i_Divisor,
    output logic [(2**g_Id_Width)-1:0]             o_Req_Ready,
    output logic                                   o_Res_Valid,
    input  logic                                   i_Res_Ready,
    output logic [g_Id_Width-1:0]                  o_Res_Id,
    output logic [g_Width-1:0]                     o_Quotient,
    output logic [g_Width-1:0]                     o_Remainder,
    output logic                                   o_Div_Zero,
    output logic                                   o_Busy
);

    localparam int N     = 2**g_Id_Width;
    localparam int CNT_W = $clog2(g_Width);

    typedef enum logic [1:0] {s_Idle, s_Divide, s_Done} state_t;

    state_t                state, state_next;
    logic [g_Id_Width-1:0] ptr;
    logic [CNT_W-1:0]      count;

    logic [g_Id_Width-1:0] id_q;
    logic [g_Width-1:0]    dvd_q;
    logic [g_Width-1:0]    divisor_q;
    logic [g_Width-1:0]    quot_q;
    logic [g_Width-1:0]    prem_q;
    logic                  dz_q;

    logic [g_Width-1:0]    dvd_arr [N];
    logic [g_Width-1:0]    dvs_arr [N];
    logic [g_Id_Width-1:0] grant_idx;
    logic [g_Id_Width-1:0] cand;
    logic                  grant_found;
    logic                  accept;
    logic [g_Width-1:0]    sel_dividend;
    logic [g_Width-1:0]    sel_divisor;
    logic [g_Width:0]      step;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The partial remainder stays below the divisor, so its low W bits of the
    // difference are exact even though the compare needs W+1 bits.
    function automatic logic [g_Width:0] div_step(
        input logic [g_Width-1:0] prem,
        input logic               bit_in,
        input logic [g_Width-1:0] divisor
    );
        logic [g_Width:0] shifted;
        shifted = {prem, bit_in};
        if (shifted >= {1'b0, divisor})
            return {1'b1, shifted[g_Width-1:0] - divisor};
        else
            return {1'b0, shifted[g_Width-1:0]};
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign dvd_arr[k] = i_Dividend[k*g_Width +: g_Width];
        assign dvs_arr[k] = i_Divisor[k*g_Width +: g_Width];
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + g_Id_Width'(i);
            if (!grant_found && i_Req_Valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Reset has priority over a handshake, so no grant is offered while it is high.
    assign accept       = (state == s_Idle) && grant_found && !i_Reset;
    assign sel_dividend = dvd_arr[grant_idx];
    assign sel_divisor  = dvs_arr[grant_idx];
    assign step         = div_step(prem_q, dvd_q[g_Width-1], divisor_q);

    always_comb begin
        o_Req_Ready = '0;
        if (accept)
            o_Req_Ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            s_Idle:
                if (accept)
                    state_next = (sel_divisor == '0) ? s_Done : s_Divide;
            s_Divide:
                if (count == CNT_W'(g_Width - 1))
                    state_next = s_Done;
            s_Done:
                if (i_Res_Ready)
                    state_next = s_Idle;
            default:
                state_next = s_Idle;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= s_Idle;
            ptr   <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            if (accept)
                count <= '0;
            else if (state == s_Divide)
                count <= count + 1'b1;
            if (state == s_Done && i_Res_Ready)
                ptr <= id_q + 1'b1;
        end
    end

    // Datapath registers carry no reset; the result outputs are gated by state.
    always_ff @(posedge i_Clk) begin
        if (accept) begin
            id_q      <= grant_idx;
            divisor_q <= sel_divisor;
            dvd_q     <= sel_dividend;
            if (sel_divisor == '0) begin
                dz_q   <= 1'b1;
                quot_q <= '1;
                prem_q <= sel_dividend;
            end else begin
                dz_q   <= 1'b0;
                quot_q <= '0;
                prem_q <= '0;
            end
        end else if (state == s_Divide) begin
            prem_q <= step[g_Width-1:0];
            quot_q <= {quot_q[g_Width-2:0], step[g_Width]};
            dvd_q  <= {dvd_q[g_Width-2:0], 1'b0};
        end
    end

    assign o_Res_Valid = (state == s_Done);
    assign o_Busy      = (state != s_Idle);
    assign o_Quotient  = o_Res_Valid ? quot_q : '0;
    assign o_Remainder = o_Res_Valid ? prem_q : '0;
    assign o_Res_Id    = o_Res_Valid ? id_q   : '0;
    assign o_Div_Zero  = o_Res_Valid && dz_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed and randomized self-checking bench for divider_arbiter (W=12, 4 requesters).
module tb_divider_arbiter;

    localparam int W  = 12;
    localparam int IW = 2;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  dividend;
    logic [N*W-1:0]  divisor;
    logic [N-1:0]    req_ready;
    logic            res_valid;
    logic            res_ready;
    logic [IW-1:0]   res_id;
    logic [W-1:0]    quot;
    logic [W-1:0]    rem;
    logic            dz;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    divider_arbiter #(.g_Width(W), .g_Id_Width(IW)) dut (
        .i_Clk       (clk),
        .i_Reset     (rst),
        .i_Req_Valid (req_valid),
        .i_Dividend  (dividend),
        .i_Divisor   (divisor),
        .o_Req_Ready (req_ready),
        .o_Res_Valid (res_valid),
        .i_Res_Ready (res_ready),
        .o_Res_Id    (res_id),
        .o_Quotient  (quot),
        .o_Remainder (rem),
        .o_Div_Zero  (dz),
        .o_Busy      (busy)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic pulse_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int id, output bit ok);
        int n = 0;
        #1;
        while (req_ready[id] !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        ok = (req_ready[id] === 1'b1);
    endtask

    task automatic wait_res_valid(output bit ok);
        int n = 0;
        while (res_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        ok = (res_valid === 1'b1);
    endtask

    // Issues one request and collects its result; lat counts edges from the grant cycle.
    task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                          output logic [IW-1:0] rid, output int lat, output bit ok);
        bit g_ok;
        q = '0; r = '0; z = 1'b0; rid = '0; lat = 0;
        dividend[id*W +: W] = a;
        divisor[id*W +: W]  = b;
        req_valid[id] = 1'b1;
        wait_grant(id, g_ok);
        if (!g_ok) begin
            req_valid[id] = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        lat = 1;
        while (res_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        ok = (res_valid === 1'b1);
        q = quot; r = rem; z = dz; rid = res_id;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '0; res_ready = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_checks++; if (quot !== 12'd0) begin n_fail++; $display("FAIL reset_quot: got %0d want 0", quot); end
        n_checks++; if (rem !== 12'd0) begin n_fail++; $display("FAIL reset_rem: got %0d want 0", rem); end
        n_checks++; if (res_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", res_id); end
        n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", dz); end
        req_valid = 4'b0001; #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_blocks_grant: got %b want 0000", req_ready); end
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [W-1:0] q, r; logic z; logic [IW-1:0] rid; int lat; bit ok;
        run_op(0, 12'd100, 12'd7, q, r, z, rid, lat, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got ok=%b want 1", ok); end
        n_checks++; if (lat != 13) begin n_fail++; $display("FAIL basic_latency: got %0d want 13", lat); end
        n_checks++; if (q !== 12'd14) begin n_fail++; $display("FAIL basic_quot: got %0d want 14", q); end
        n_checks++; if (r !== 12'd2) begin n_fail++; $display("FAIL basic_rem: got %0d want 2", r); end
        n_checks++; if (rid !== 2'd0) begin n_fail++; $display("FAIL basic_id: got %0d want 0", rid); end
        n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b want 0", z); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", res_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_operands;
        int ids [3] = '{2, 1, 3};
        int as  [3] = '{4095, 5, 4095};
        int bs  [3] = '{1, 9, 4095};
        int eq  [3] = '{4095, 0, 1};
        int er  [3] = '{0, 5, 0};
        logic [W-1:0] q, r; logic z; logic [IW-1:0] rid; int lat; bit ok;
        for (int i = 0; i < 3; i++) begin
            run_op(ids[i], W'(as[i]), W'(bs[i]), q, r, z, rid, lat, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL operands_timeout[%0d]: got ok=%b want 1", i, ok); end
            n_checks++; if (q !== W'(eq[i])) begin n_fail++; $display("FAIL operands_quot[%0d]: got %0d want %0d", i, q, eq[i]); end
            n_checks++; if (r !== W'(er[i])) begin n_fail++; $display("FAIL operands_rem[%0d]: got %0d want %0d", i, r, er[i]); end
            n_checks++; if (rid !== IW'(ids[i])) begin n_fail++; $display("FAIL operands_id[%0d]: got %0d want %0d", i, rid, ids[i]); end
            n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL operands_dz[%0d]: got %b want 0", i, z); end
        end
    endtask

    task automatic test_div_zero;
        logic [W-1:0] q, r; logic z; logic [IW-1:0] rid; int lat; bit ok;
        run_op(1, 12'd37, 12'd0, q, r, z, rid, lat, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL dz_timeout: got ok=%b want 1", ok); end
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_checks++; if (q !== 12'd4095) begin n_fail++; $display("FAIL dz_quot: got %0d want 4095", q); end
        n_checks++; if (r !== 12'd37) begin n_fail++; $display("FAIL dz_rem: got %0d want 37", r); end
        n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", z); end
        n_checks++; if (rid !== 2'd1) begin n_fail++; $display("FAIL dz_id: got %0d want 1", rid); end
    endtask

    task automatic test_round_robin;
        int grants[$];
        bit multi = 0, overlap = 0;
        int cyc = 0, exp_q, exp_r;
        pulse_reset();
        for (int k = 0; k < N; k++) begin
            dividend[k*W +: W] = W'(100 + k);
            divisor[k*W +: W]  = W'(k + 1);
        end
        req_valid = '1; res_ready = 1'b1;
        while (grants.size() < 6 && cyc < 200) begin
            #1;
            if ($countones(req_ready) > 1) multi = 1;
            if (res_valid && req_ready != '0) overlap = 1;
            if (res_valid) begin
                exp_q = (100 + int'(res_id)) / (int'(res_id) + 1);
                exp_r = (100 + int'(res_id)) % (int'(res_id) + 1);
                n_checks++; if (quot !== W'(exp_q) || rem !== W'(exp_r)) begin n_fail++;
                    $display("FAIL rr_result id%0d: got q=%0d r=%0d want q=%0d r=%0d", res_id, quot, rem, exp_q, exp_r); end
            end
            for (int k = 0; k < N; k++) if (req_ready[k]) grants.push_back(k);
            @(posedge clk); #1; cyc++;
        end
        req_valid = '0;
        cyc = 0;
        while (busy && cyc < 30) begin @(posedge clk); #1; cyc++; end
        res_ready = 1'b0;
        n_checks++; if (grants.size() != 6) begin n_fail++; $display("FAIL rr_grant_count: got %0d want 6", grants.size()); end
        for (int i = 0; i < grants.size() && i < 6; i++) begin
            n_checks++; if (grants[i] != i % 4) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, grants[i], i % 4); end
        end
        n_checks++; if (multi) begin n_fail++; $display("FAIL rr_onehot: got multiple ready bits, want at most one"); end
        n_checks++; if (overlap) begin n_fail++; $display("FAIL rr_valid_ready_overlap: got both high, want never"); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got busy=%b want 0", busy); end
    endtask

    task automatic test_backpressure;
        bit ok;
        pulse_reset();
        dividend[0*W +: W] = 12'd200; divisor[0*W +: W] = 12'd9;
        dividend[2*W +: W] = 12'd50;  divisor[2*W +: W] = 12'd5;
        req_valid = 4'b0101; res_ready = 1'b0;
        wait_grant(0, ok);
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_first_grant: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_res_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got ok=%b want 1", ok); end
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, res_valid); end
            n_checks++; if (quot !== 12'd22) begin n_fail++; $display("FAIL bp_hold_quot c%0d: got %0d want 22", c, quot); end
            n_checks++; if (rem !== 12'd2) begin n_fail++; $display("FAIL bp_hold_rem c%0d: got %0d want 2", c, rem); end
            n_checks++; if (res_id !== 2'd0) begin n_fail++; $display("FAIL bp_hold_id c%0d: got %0d want 0", c, res_id); end
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_no_grant c%0d: got %b want 0000", c, req_ready); end
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", res_valid); end
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_next_grant: got %b want 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        wait_res_valid(ok);
        n_checks++; if (!ok || quot !== 12'd10 || rem !== 12'd0 || res_id !== 2'd2) begin n_fail++;
            $display("FAIL bp_second_result: got q=%0d r=%0d id=%0d want q=10 r=0 id=2", quot, rem, res_id); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] q, r; logic z; logic [IW-1:0] rid; int lat; bit ok;
        bit seen = 0;
        dividend[0*W +: W] = 12'd1000; divisor[0*W +: W] = 12'd3;
        req_valid = 4'b0001;
        wait_grant(0, ok);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", res_valid); end
        n_checks++; if (quot !== 12'd0 || rem !== 12'd0 || res_id !== 2'd0 || dz !== 1'b0) begin n_fail++;
            $display("FAIL mid_reset_outputs: got q=%0d r=%0d id=%0d dz=%b want all 0", quot, rem, res_id, dz); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 0000", req_ready); end
        for (int c = 0; c < 20; c++) begin
            if (res_valid) seen = 1;
            @(posedge clk); #1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL mid_reset_no_result: got a result, want none"); end
        req_valid = 4'b1010; #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_reset_pointer: got %b want 0010", req_ready); end
        req_valid = 4'b0010; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_beats_handshake: got busy=%b want 0", busy); end
        run_op(3, 12'd4000, 12'd7, q, r, z, rid, lat, ok);
        n_checks++; if (!ok || q !== 12'd571 || r !== 12'd3 || rid !== 2'd3 || z !== 1'b0) begin n_fail++;
            $display("FAIL mid_reset_recover: got ok=%b q=%0d r=%0d id=%0d dz=%b want q=571 r=3 id=3 dz=0", ok, q, r, rid, z); end
    endtask

    task automatic test_random;
        logic [W-1:0] q, r; logic z; logic [IW-1:0] rid; int lat; bit ok;
        int id, a, b, eq, er, nshow = 0;
        for (int i = 0; i < 1000; i++) begin
            id = $urandom_range(0, N-1);
            a  = $urandom_range(0, 4095);
            case ($urandom_range(0, 7))
                0:       b = 0;
                1:       b = $urandom_range(1, 15);
                default: b = $urandom_range(1, 4095);
            endcase
            eq = (b == 0) ? 4095 : a / b;
            er = (b == 0) ? a : a % b;
            run_op(id, W'(a), W'(b), q, r, z, rid, lat, ok);
            n_checks++;
            if (!ok || q !== W'(eq) || r !== W'(er) || rid !== IW'(id) || z !== (b == 0)) begin
                n_fail++;
                if (nshow < 10) begin
                    nshow++;
                    $display("FAIL random_op%0d %0d/%0d id%0d: got ok=%b q=%0d r=%0d id=%0d dz=%b want q=%0d r=%0d",
                             i, a, b, id, ok, q, r, rid, z, eq, er);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_operands();
        test_div_zero();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
